alu_issue_stage: RTL and testbench

//  Decode/issue stage that produces the ALU's operand and control inputs (A, B, ALU_control).

---
 rtl/alu_issue_stage.sv | 181 ++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// RV32I decode/issue stage: builds ALU operands and control, registered behind a valid/ready skid-free stage.
// Optional: define ILLEGAL_COUNT_EN to add a saturating illegal-instruction counter output.
module alu_issue_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 4
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [XLEN-1:0]   pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   A,
  output logic [XLEN-1:0]   B,
  output logic [CTRL_W-1:0] ALU_control,
  output logic [4:0]        rd,
  output logic              illegal
`ifdef ILLEGAL_COUNT_EN
  ,
  output logic [15:0]       illegal_count
`endif
);

  localparam logic [CTRL_W-1:0] C_ADD  = CTRL_W'(0);
  localparam logic [CTRL_W-1:0] C_SUB  = CTRL_W'(1);
  localparam logic [CTRL_W-1:0] C_AND  = CTRL_W'(2);
  localparam logic [CTRL_W-1:0] C_OR   = CTRL_W'(3);
  localparam logic [CTRL_W-1:0] C_XOR  = CTRL_W'(4);
  localparam logic [CTRL_W-1:0] C_SLL  = CTRL_W'(5);
  localparam logic [CTRL_W-1:0] C_SRL  = CTRL_W'(6);
  localparam logic [CTRL_W-1:0] C_SRA  = CTRL_W'(7);
  localparam logic [CTRL_W-1:0] C_SLTU = CTRL_W'(8);
  localparam logic [CTRL_W-1:0] C_SLT  = CTRL_W'(9);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Shared funct3 map for R-type and I-ALU; alt selects SUB/SRA.
  function automatic logic [CTRL_W-1:0] f3_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  f3_op = alt ? C_SUB : C_ADD;
      3'b001:  f3_op = C_SLL;
      3'b010:  f3_op = C_SLT;
      3'b011:  f3_op = C_SLTU;
      3'b100:  f3_op = C_XOR;
      3'b101:  f3_op = alt ? C_SRA : C_SRL;
      3'b110:  f3_op = C_OR;
      default: f3_op = C_AND;
    endcase
  endfunction

  logic [6:0]        w_opcode;
  logic [2:0]        w_f3;
  logic [6:0]        w_f7;
  logic [XLEN-1:0]   w_imm_i;
  logic [XLEN-1:0]   w_imm_s;
  logic [XLEN-1:0]   w_imm_u;
  logic [XLEN-1:0]   w_shamt;
  logic [XLEN-1:0]   w_a;
  logic [XLEN-1:0]   w_b;
  logic [CTRL_W-1:0] w_ctrl;
  logic [4:0]        w_rd;
  logic              w_ill;
  logic              w_accept;

  assign w_opcode = instr[6:0];
  assign w_f3     = instr[14:12];
  assign w_f7     = instr[31:25];
  assign w_imm_i  = XLEN'($signed(instr[31:20]));
  assign w_imm_s  = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign w_imm_u  = XLEN'($signed({instr[31:12], 12'b0}));
  assign w_shamt  = XLEN'(instr[24:20]);

  assign in_ready = !out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    w_a    = '0;
    w_b    = '0;
    w_ctrl = C_ADD;
    w_rd   = instr[11:7];
    w_ill  = 1'b0;
    case (w_opcode)
      OP_R: begin
        w_a    = rs1_data;
        w_b    = rs2_data;
        w_ctrl = f3_op(w_f3, w_f7[5]);
        w_ill  = !((w_f7 == 7'b0000000) ||
                   (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)));
      end
      OP_I: begin
        w_a    = rs1_data;
        w_b    = w_imm_i;
        w_ctrl = f3_op(w_f3, (w_f3 == 3'b101) && w_f7[5]);
        if (w_f3 == 3'b001) begin
          w_b   = w_shamt;
          w_ill = (w_f7 != 7'b0000000);
        end else if (w_f3 == 3'b101) begin
          w_b   = w_shamt;
          w_ill = (w_f7 != 7'b0000000) && (w_f7 != 7'b0100000);
        end
      end
      OP_LUI:   w_b = w_imm_u;
      OP_AUIPC: begin
        w_a = pc;
        w_b = w_imm_u;
      end
      OP_LOAD: begin
        w_a = rs1_data;
        w_b = w_imm_i;
      end
      OP_STORE: begin
        w_a  = rs1_data;
        w_b  = w_imm_s;
        w_rd = 5'd0;
      end
      OP_BRANCH: begin
        w_a  = rs1_data;
        w_b  = rs2_data;
        w_rd = 5'd0;
        case (w_f3[2:1])
          2'b00:   w_ctrl = C_SUB;
          2'b10:   w_ctrl = C_SLT;
          2'b11:   w_ctrl = C_SLTU;
          default: w_ill  = 1'b1;
        endcase
      end
      default: w_ill = 1'b1;
    endcase
    // Illegal words carry a clean all-zero payload so the ALU side never sees stray operands.
    if (w_ill) begin
      w_a    = '0;
      w_b    = '0;
      w_ctrl = C_ADD;
      w_rd   = 5'd0;
    end
  end

  // NOTE: the payload registers are reset too, because outputs must read zero during reset, not just be ignored.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      out_valid   <= 1'b0;
      A           <= '0;
      B           <= '0;
      ALU_control <= C_ADD;
      rd          <= 5'd0;
      illegal     <= 1'b0;
    end else if (w_accept) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      out_valid   <= 1'b1;
      A           <= w_a;
      B           <= w_b;
      ALU_control <= w_ctrl;
      rd          <= w_rd;
      illegal     <= w_ill;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

`ifdef ILLEGAL_COUNT_EN
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      illegal_count <= 16'd0;
    end else if (w_accept && w_ill && (illegal_count != 16'hFFFF)) begin
      illegal_count <= illegal_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: spec-level decode model with per-cycle compare plus literal anchors.
// Follows ILLEGAL_COUNT_EN the same way as the design.
module tb_alu_issue_stage;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3, OP_XOR = 4'd4,
    OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7, OP_SLTU = 4'd8, OP_SLT = 4'd9
  } op_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    op_t         ctrl;
    logic [4:0]  rd;
    logic        ill;
  } word_t;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] p;
  } vec_t;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = 32'h0;
  logic [31:0] rs1_data = 32'h0;
  logic [31:0] rs2_data = 32'h0;
  logic [31:0] pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALU_control;
  logic [4:0]  rd;
  logic        illegal;
`ifdef ILLEGAL_COUNT_EN
  logic [15:0] illegal_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  alu_issue_stage #(.XLEN(32), .CTRL_W(4)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data), .pc(pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .A(A), .B(B), .ALU_control(ALU_control), .rd(rd), .illegal(illegal)
`ifdef ILLEGAL_COUNT_EN
    , .illegal_count(illegal_count)
`endif
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  op_t base_op [8] = '{OP_ADD, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_OR, OP_AND};

  function automatic word_t model_decode(input logic [31:0] ins, input logic [31:0] r1,
                                         input logic [31:0] r2, input logic [31:0] p);
    word_t w;
    logic [6:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    w.a = 32'h0; w.b = 32'h0; w.ctrl = OP_ADD; w.rd = ins[11:7]; w.ill = 1'b0;
    case (op)
      7'h33: begin
        w.a = r1; w.b = r2;
        if (f7 == 7'h00)                    w.ctrl = base_op[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) w.ctrl = OP_SUB;
        else if (f7 == 7'h20 && f3 == 3'd5) w.ctrl = OP_SRA;
        else                                w.ill  = 1'b1;
      end
      7'h13: begin
        w.a = r1;
        w.b = 32'($signed(ins[31:20]));
        w.ctrl = base_op[f3];
        if (f3 == 3'd1 || f3 == 3'd5) begin
          w.b = {27'h0, ins[24:20]};
          if (f3 == 3'd5 && f7 == 7'h20) w.ctrl = OP_SRA;
          else if (f7 != 7'h00)          w.ill  = 1'b1;
        end
      end
      7'h37: w.b = {ins[31:12], 12'h000};
      7'h17: begin w.a = p;  w.b = {ins[31:12], 12'h000}; end
      7'h03: begin w.a = r1; w.b = 32'($signed(ins[31:20])); end
      7'h23: begin w.a = r1; w.b = 32'($signed({ins[31:25], ins[11:7]})); w.rd = 5'd0; end
      7'h63: begin
        w.a = r1; w.b = r2; w.rd = 5'd0;
        if (f3 == 3'd0 || f3 == 3'd1)      w.ctrl = OP_SUB;
        else if (f3 == 3'd4 || f3 == 3'd5) w.ctrl = OP_SLT;
        else if (f3 == 3'd6 || f3 == 3'd7) w.ctrl = OP_SLTU;
        else                               w.ill  = 1'b1;
      end
      default: w.ill = 1'b1;
    endcase
    if (w.ill) begin
      w.a = 32'h0; w.b = 32'h0; w.ctrl = OP_ADD; w.rd = 5'd0;
    end
    return w;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] c);
    case (c)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      4'd7:    return 32'($signed(a) >>> b[4:0]);
      4'd8:    return {31'h0, a < b};
      4'd9:    return {31'h0, $signed(a) < $signed(b)};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  logic        exp_valid = 1'b0;
  word_t       exp_w = '{32'h0, 32'h0, OP_ADD, 5'd0, 1'b0};
  logic [15:0] exp_cnt = 16'h0;

  always @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      exp_valid <= 1'b0;
      exp_cnt   <= 16'h0;
    end else if (in_valid && (!exp_valid || out_ready)) begin
      exp_valid <= 1'b1;
      exp_w     <= model_decode(instr, rs1_data, rs2_data, pc);
      if (model_decode(instr, rs1_data, rs2_data, pc).ill && exp_cnt != 16'hFFFF)
        exp_cnt <= exp_cnt + 16'h1;
    end else if (out_ready) begin
      exp_valid <= 1'b0;
    end
  end

  // Compare process: checks DUT against the model away from the active edge.
  always @(negedge CLOCK) begin
    check("out_valid", {31'h0, out_valid}, {31'h0, exp_valid});
    check("in_ready", {31'h0, in_ready}, {31'h0, (!exp_valid || out_ready)});
`ifdef ILLEGAL_COUNT_EN
    check("illegal_count", {16'h0, illegal_count}, {16'h0, exp_cnt});
`endif
    if (exp_valid) begin
      check("A", A, exp_w.a);
      check("B", B, exp_w.b);
      check("ALU_control", {28'h0, ALU_control}, {28'h0, exp_w.ctrl});
      check("rd", {27'h0, rd}, {27'h0, exp_w.rd});
      check("illegal", {31'h0, illegal}, {31'h0, exp_w.ill});
      n_vec++;
      alu_result_ok: assert (alu_ref(A, B, ALU_control) == alu_ref(exp_w.a, exp_w.b, exp_w.ctrl))
      else begin
        n_err++;
        $display("FAIL alu_result: got %h expected %h at %0t", alu_ref(A, B, ALU_control),
                 alu_ref(exp_w.a, exp_w.b, exp_w.ctrl), $time);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [31:0] ins, input logic [31:0] r1,
                      input logic [31:0] r2, input logic [31:0] p);
    in_valid = 1'b1;
    instr = ins; rs1_data = r1; rs2_data = r2; pc = p;
    @(posedge CLOCK);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLOCK);
    #1;
  endtask

  vec_t vecs [$];

  initial begin
    vecs = '{
      '{{7'h00, 5'd2, 5'd1, 3'd6, 5'd3, 7'h33}, 32'hF0F0_0000, 32'h0000_0F0F, 32'h0},   // or
      '{{7'h00, 5'd2, 5'd1, 3'd7, 5'd3, 7'h33}, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0},   // and
      '{{7'h00, 5'd2, 5'd1, 3'd1, 5'd4, 7'h33}, 32'h0000_0001, 32'h0000_001F, 32'h0},   // sll
      '{{7'h00, 5'd2, 5'd1, 3'd2, 5'd5, 7'h33}, 32'hFFFF_FFFB, 32'h0000_0003, 32'h0},   // slt
      '{{7'h00, 5'd2, 5'd1, 3'd3, 5'd6, 7'h33}, 32'hFFFF_FFFB, 32'h0000_0003, 32'h0},   // sltu
      '{{7'h20, 5'd2, 5'd1, 3'd5, 5'd7, 7'h33}, 32'h8000_0000, 32'h0000_0004, 32'h0},   // sra
      '{{7'h00, 5'd2, 5'd1, 3'd5, 5'd7, 7'h33}, 32'h8000_0000, 32'h0000_0004, 32'h0},   // srl
      '{{7'h20, 5'd2, 5'd1, 3'd7, 5'd7, 7'h33}, 32'h1234_5678, 32'h1, 32'h0},           // bad f7
      '{{7'h01, 5'd2, 5'd1, 3'd0, 5'd7, 7'h33}, 32'h1234_5678, 32'h1, 32'h0},           // mul: illegal
      '{{12'hF00, 5'd1, 3'd4, 5'd7, 7'h13}, 32'h0000_00FF, 32'h0, 32'h0},               // xori
      '{{12'h800, 5'd1, 3'd2, 5'd8, 7'h13}, 32'h0000_0000, 32'h0, 32'h0},               // slti
      '{{12'h800, 5'd1, 3'd3, 5'd8, 7'h13}, 32'h0000_0000, 32'h0, 32'h0},               // sltiu
      '{{12'h0F0, 5'd1, 3'd6, 5'd9, 7'h13}, 32'h0000_000F, 32'h0, 32'h0},               // ori
      '{{12'h7FF, 5'd1, 3'd7, 5'd9, 7'h13}, 32'hFFFF_FFFF, 32'h0, 32'h0},               // andi
      '{{7'h00, 5'd5, 5'd1, 3'd1, 5'd2, 7'h13}, 32'h0000_0003, 32'h0, 32'h0},           // slli
      '{{7'h20, 5'd5, 5'd1, 3'd1, 5'd2, 7'h13}, 32'h0000_0003, 32'h0, 32'h0},           // slli bad f7
      '{{7'h00, 5'd31, 5'd1, 3'd5, 5'd2, 7'h13}, 32'h8000_0000, 32'h0, 32'h0},          // srli
      '{{7'h10, 5'd1, 5'd1, 3'd5, 5'd2, 7'h13}, 32'h8000_0000, 32'h0, 32'h0},           // shift bad f7
      '{{20'hABCDE, 5'd6, 7'h17}, 32'h0, 32'h0, 32'h0000_1000},                         // auipc
      '{{12'h804, 5'd1, 3'd2, 5'd8, 7'h03}, 32'h0000_2000, 32'h0, 32'h0},               // lw
      '{{7'h7F, 5'd2, 5'd1, 3'd2, 5'h1F, 7'h23}, 32'h0000_3000, 32'h55, 32'h0},         // sw
      '{{7'h00, 5'd2, 5'd1, 3'd0, 5'd4, 7'h63}, 32'h0000_0010, 32'h0000_0010, 32'h0},   // beq
      '{{7'h00, 5'd2, 5'd1, 3'd5, 5'd4, 7'h63}, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0},   // bge
      '{{7'h00, 5'd2, 5'd1, 3'd6, 5'd4, 7'h63}, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0},   // bltu
      '{{7'h00, 5'd2, 5'd1, 3'd2, 5'd4, 7'h63}, 32'h1, 32'h2, 32'h0},                   // branch f3=010
      '{32'h0000_006F, 32'h1, 32'h2, 32'h0}                                              // jal: illegal
    };

    // Reset state
    #3;
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_A", A, 32'h0);
    check("rst_B", B, 32'h0);
    check("rst_ctrl", {28'h0, ALU_control}, 32'h0);
    check("rst_rd", {27'h0, rd}, 32'h0);
    check("rst_illegal", {31'h0, illegal}, 32'h0);
`ifdef ILLEGAL_COUNT_EN
    check("rst_illegal_count", {16'h0, illegal_count}, 32'h0);
`endif
    #14 RESET = 1'b0;
    idle(1);

    // add x3,x1,x2
    send(32'h0020_81B3, 32'd5, 32'd7, 32'h0);
    check("t1_A", A, 32'd5);
    check("t1_B", B, 32'd7);
    check("t1_ctrl", {28'h0, ALU_control}, 32'h0);
    check("t1_rd", {27'h0, rd}, 32'd3);
    idle(1);

    // sub then srai back-to-back
    send(32'h4020_81B3, 32'd20, 32'd3, 32'h0);
    check("t2_sub_ctrl", {28'h0, ALU_control}, 32'h1);
    send(32'h4031_5093, 32'h8000_0000, 32'h0, 32'h0);
    check("t2_srai_valid", {31'h0, out_valid}, 32'h1);
    check("t2_srai_ctrl", {28'h0, ALU_control}, 32'h7);
    check("t2_srai_B", B, 32'd3);
    check("t2_srai_rd", {27'h0, rd}, 32'd1);

    // addi -1, lui
    send(32'hFFF0_0093, 32'h0, 32'h0, 32'h0);
    check("t3_addi_B", B, 32'hFFFF_FFFF);
    send(32'h1234_52B7, 32'hAAAA_AAAA, 32'h0, 32'h0);
    check("t3_lui_A", A, 32'h0);
    check("t3_lui_B", B, 32'h1234_5000);
    check("t3_lui_rd", {27'h0, rd}, 32'd5);

    // Stall: xor x4,x1,x2 held while a new word waits
    send({7'h00, 5'd2, 5'd1, 3'd4, 5'd4, 7'h33}, 32'hF0, 32'h0F, 32'h0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr = 32'h0020_81B3; rs1_data = 32'd1; rs2_data = 32'd2; pc = 32'h0;
    repeat (3) begin
      @(posedge CLOCK);
      #1;
      check("t4_hold_valid", {31'h0, out_valid}, 32'h1);
      check("t4_hold_A", A, 32'hF0);
      check("t4_hold_B", B, 32'h0F);
      check("t4_hold_ctrl", {28'h0, ALU_control}, 32'h4);
      check("t4_in_ready", {31'h0, in_ready}, 32'h0);
    end
    out_ready = 1'b1;
    @(posedge CLOCK);
    #1;
    in_valid = 1'b0;
    check("t4_release_A", A, 32'd1);
    check("t4_release_B", B, 32'd2);
    check("t4_release_ctrl", {28'h0, ALU_control}, 32'h0);
    idle(1);

    // Undecodable opcode
    send(32'h0000_007F, 32'h1111_1111, 32'h2222_2222, 32'h0);
    check("t5_illegal", {31'h0, illegal}, 32'h1);
    check("t5_ctrl", {28'h0, ALU_control}, 32'h0);
    check("t5_A", A, 32'h0);
    check("t5_B", B, 32'h0);
`ifdef ILLEGAL_COUNT_EN
    check("t5_illegal_count", {16'h0, illegal_count}, 32'h1);
`endif
    idle(1);

    // Directed table under periodic back-pressure; words offered while stalled are dropped
    for (int i = 0; i < vecs.size(); i++) begin
      out_ready = (i % 3) != 2;
      send(vecs[i].ins, vecs[i].r1, vecs[i].r2, vecs[i].p);
    end
    out_ready = 1'b1;
    idle(2);

    // Reset while a word is held
    send(32'h0020_81B3, 32'd9, 32'd9, 32'h0);
    out_ready = 1'b0;
    #2 RESET = 1'b1;
    #1;
    check("t6_out_valid", {31'h0, out_valid}, 32'h0);
    check("t6_A", A, 32'h0);
    check("t6_B", B, 32'h0);
    check("t6_ctrl", {28'h0, ALU_control}, 32'h0);
    check("t6_rd", {27'h0, rd}, 32'h0);
    check("t6_illegal", {31'h0, illegal}, 32'h0);
`ifdef ILLEGAL_COUNT_EN
    check("t6_illegal_count", {16'h0, illegal_count}, 32'h0);
`endif
    idle(1);
    #2 RESET = 1'b0;
    out_ready = 1'b1;
    idle(1);
    send(32'h4020_81B3, 32'd100, 32'd1, 32'h0);
    check("t6_after_A", A, 32'd100);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
